// File: rtl/rst_req_pkg.sv
// Shared types and helpers for the soft-reset request controller.
// The watchdog is present only when RST_REQ_CTRL_WDT_EN is defined.
package rst_req_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StAssert,
        StRelease
    } state_e;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_POR = 2'b00;
    localparam cause_t CAUSE_SW  = 2'b01;
    localparam cause_t CAUSE_WDT = 2'b10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0 .. n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rst_req_wdt.sv
// Watchdog down-counter for rst_req_ctrl; raises a one-cycle fire on the 1->0 step.
// Instantiated only when RST_REQ_CTRL_WDT_EN is defined.
module rst_req_wdt
    import rst_req_pkg::*;
#(
    parameter int unsigned WDT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 kick_i,
    input  logic [WDT_WIDTH-1:0] val_i,
    input  logic                 idle_i,
    output logic                 fire_o
);

    logic [WDT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 en_d, en_q;
    logic                 load;

    always_comb begin
        en_d   = en_i;
        cnt_d  = cnt_q;
        fire_o = 1'b0;
        load   = (en_i && !en_q) || kick_i;
        if (load) begin
            cnt_d = val_i;
        end else if (en_i && idle_i && (cnt_q != '0)) begin
            // Counting stops at zero, so a zero load never fires.
            cnt_d  = cnt_q - 1'b1;
            fire_o = (cnt_q == WDT_WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: rtl/rst_req_ctrl.sv
// Soft-reset request controller: drain, pulse soft_reset_en, wait for core reset release.
// Optional watchdog request source enabled by RST_REQ_CTRL_WDT_EN.
module rst_req_ctrl
    import rst_req_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = 16,
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned WDT_WIDTH     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sw_req_i,
    output logic                 drain_req_o,
    input  logic                 drain_ack_i,
    output logic                 soft_reset_en_o,
    input  logic                 c_rstn_i,
    output logic                 busy_o,
    output logic [1:0]           cause_o,
    output logic                 forced_o,
`ifdef RST_REQ_CTRL_WDT_EN
    input  logic                 wdt_en_i,
    input  logic                 wdt_kick_i,
    input  logic [WDT_WIDTH-1:0] wdt_val_i,
`endif
    input  logic                 cause_clr_i
);

    localparam int unsigned     CntW      = cnt_width(max_u(DRAIN_TIMEOUT, PULSE_CYCLES));
    localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_TIMEOUT - 1);
    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);

    state_e          state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    cause_t          cause_pend_d, cause_pend_q;
    cause_t          cause_d, cause_q;
    logic            forced_d, forced_q;
    logic            drain_req_d, drain_req_q;
    logic            soft_rst_d, soft_rst_q;
    logic            busy_d, busy_q;
    logic            wdt_fire;
    logic            enter_assert;
    logic            timed_out;

`ifdef RST_REQ_CTRL_WDT_EN
    rst_req_wdt #(
        .WDT_WIDTH(WDT_WIDTH)
    ) u_wdt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (wdt_en_i),
        .kick_i (wdt_kick_i),
        .val_i  (wdt_val_i),
        .idle_i (state_q == StIdle),
        .fire_o (wdt_fire)
    );
`else
    logic unused_wdt_width;
    assign unused_wdt_width = ^WDT_WIDTH;
    assign wdt_fire         = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cause_pend_d = cause_pend_q;
        enter_assert = 1'b0;
        timed_out    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sw_req_i || wdt_fire) begin
                    state_d      = StDrain;
                    cnt_d        = '0;
                    cause_pend_d = wdt_fire ? CAUSE_WDT : CAUSE_SW;
                end
            end
            StDrain: begin
                if (drain_ack_i) begin
                    state_d      = StAssert;
                    cnt_d        = '0;
                    enter_assert = 1'b1;
                end else if (cnt_q == DrainLast) begin
                    state_d      = StAssert;
                    cnt_d        = '0;
                    enter_assert = 1'b1;
                    timed_out    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAssert: begin
                if (cnt_q == PulseLast) begin
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (c_rstn_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // The ASSERT-entry update takes precedence over a concurrent clear.
        cause_d  = cause_q;
        forced_d = forced_q;
        if (enter_assert) begin
            cause_d  = cause_pend_q;
            forced_d = timed_out;
        end else if (cause_clr_i) begin
            cause_d  = CAUSE_POR;
            forced_d = 1'b0;
        end

        // Outputs are decoded from the next state so they leave as flop outputs.
        drain_req_d = (state_d != StIdle);
        soft_rst_d  = (state_d == StAssert);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cause_pend_q <= CAUSE_POR;
            cause_q      <= CAUSE_POR;
            forced_q     <= 1'b0;
            drain_req_q  <= 1'b0;
            soft_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_pend_q <= cause_pend_d;
            cause_q      <= cause_d;
            forced_q     <= forced_d;
            drain_req_q  <= drain_req_d;
            soft_rst_q   <= soft_rst_d;
            busy_q       <= busy_d;
        end
    end

    assign drain_req_o     = drain_req_q;
    assign soft_reset_en_o = soft_rst_q;
    assign busy_o          = busy_q;
    assign cause_o         = cause_q;
    assign forced_o        = forced_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Self-checking bench for rst_req_ctrl; watchdog scenarios run when RST_REQ_CTRL_WDT_EN is defined.
// Completed soft_reset_en pulses are recorded by a monitor and matched against expected records.
module tb_rst_req_ctrl;
    import rst_req_pkg::*;

    localparam int unsigned Pulse   = 16;
    localparam int unsigned Timeout = 8;
    localparam int unsigned WdtW    = 8;

    typedef struct {
        int         len;
        logic [1:0] cause;
        logic       forced;
    } pulse_t;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            sw_req_i, drain_ack_i, c_rstn_i, cause_clr_i;
    logic            drain_req_o, soft_reset_en_o, busy_o, forced_o;
    logic [1:0]      cause_o;
    logic            wdt_en_i, wdt_kick_i;
    logic [WdtW-1:0] wdt_val_i;

    pulse_t exp_q[$];
    pulse_t obs_q[$];
    int     run = 0;
    int     n_vec = 0;
    int     n_err = 0;

    rst_req_ctrl #(
        .PULSE_CYCLES (Pulse),
        .DRAIN_TIMEOUT(Timeout),
        .WDT_WIDTH    (WdtW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sw_req_i       (sw_req_i),
        .drain_req_o    (drain_req_o),
        .drain_ack_i    (drain_ack_i),
        .soft_reset_en_o(soft_reset_en_o),
        .c_rstn_i       (c_rstn_i),
        .busy_o         (busy_o),
        .cause_o        (cause_o),
        .forced_o       (forced_o),
`ifdef RST_REQ_CTRL_WDT_EN
        .wdt_en_i       (wdt_en_i),
        .wdt_kick_i     (wdt_kick_i),
        .wdt_val_i      (wdt_val_i),
`endif
        .cause_clr_i    (cause_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Pulse monitor; a pulse cut short by rst_ni is discarded.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            run = 0;
        end else if (soft_reset_en_o) begin
            run++;
        end else if (run != 0) begin
            obs_q.push_back('{len: run, cause: cause_o, forced: forced_o});
            run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        sw_req_i = 1'b0; drain_ack_i = 1'b0; c_rstn_i = 1'b0; cause_clr_i = 1'b0;
        wdt_en_i = 1'b0; wdt_kick_i = 1'b0; wdt_val_i = '0;
        tick(); tick();
        n_vec++; if (drain_req_o !== 1'b0) begin n_err++;
            $display("FAIL reset_drain_req: got %b want 0", drain_req_o); end
        n_vec++; if (soft_reset_en_o !== 1'b0) begin n_err++;
            $display("FAIL reset_soft_rst: got %b want 0", soft_reset_en_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++;
            $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_vec++; if (cause_o !== CAUSE_POR) begin n_err++;
            $display("FAIL reset_cause: got %b want 00", cause_o); end
        n_vec++; if (forced_o !== 1'b0) begin n_err++;
            $display("FAIL reset_forced: got %b want 0", forced_o); end
        rst_ni = 1'b1;
        tick(); tick();
        n_vec++; if (busy_o !== 1'b0) begin n_err++;
            $display("FAIL idle_after_reset_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_sw_ack();
        pulse_t e, o;
        c_rstn_i = 1'b0;
        sw_req_i = 1'b1;
        exp_q.push_back('{len: Pulse, cause: CAUSE_SW, forced: 1'b0});
        tick(); sw_req_i = 1'b0;
        n_vec++; if (drain_req_o !== 1'b1 || busy_o !== 1'b1) begin n_err++;
            $display("FAIL sw_latency: got drain %b busy %b want 1 1", drain_req_o, busy_o); end
        tick(); tick(); tick();
        drain_ack_i = 1'b1;
        n_vec++; if (soft_reset_en_o !== 1'b0) begin n_err++;
            $display("FAIL sw_pre_ack_soft: got %b want 0", soft_reset_en_o); end
        tick(); drain_ack_i = 1'b0;
        n_vec++; if (soft_reset_en_o !== 1'b1) begin n_err++;
            $display("FAIL sw_ack_soft: got %b want 1", soft_reset_en_o); end
        n_vec++; if (cause_o !== CAUSE_SW || forced_o !== 1'b0) begin n_err++;
            $display("FAIL sw_cause: got %b/%b want 01/0", cause_o, forced_o); end
        repeat (Pulse - 1) tick();
        n_vec++; if (soft_reset_en_o !== 1'b1) begin n_err++;
            $display("FAIL sw_pulse_last: got %b want 1", soft_reset_en_o); end
        tick();
        n_vec++; if (soft_reset_en_o !== 1'b0 || drain_req_o !== 1'b1) begin n_err++;
            $display("FAIL sw_release: got soft %b drain %b want 0 1", soft_reset_en_o,
                     drain_req_o); end
        c_rstn_i = 1'b1;
        tick();
        n_vec++; if (busy_o !== 1'b0 || drain_req_o !== 1'b0) begin n_err++;
            $display("FAIL sw_done: got busy %b drain %b want 0 0", busy_o, drain_req_o); end
        e = exp_q.pop_front();
        n_vec++;
        if (obs_q.size() == 0) begin n_err++;
            $display("FAIL sw_pulse_sb: no pulse, want len %0d", e.len);
        end else begin
            o = obs_q.pop_front();
            if (o.len != e.len || o.cause !== e.cause || o.forced !== e.forced) begin n_err++;
                $display("FAIL sw_pulse_sb: got %0d/%b/%b want %0d/%b/%b", o.len, o.cause,
                         o.forced, e.len, e.cause, e.forced); end
        end
    endtask

    task automatic test_timeout();
        pulse_t e, o;
        c_rstn_i = 1'b0;
        sw_req_i = 1'b1;
        exp_q.push_back('{len: Pulse, cause: CAUSE_SW, forced: 1'b1});
        tick(); sw_req_i = 1'b0;
        repeat (Timeout - 1) tick();
        n_vec++; if (soft_reset_en_o !== 1'b0 || drain_req_o !== 1'b1) begin n_err++;
            $display("FAIL timeout_early: got soft %b drain %b want 0 1", soft_reset_en_o,
                     drain_req_o); end
        tick();
        n_vec++; if (soft_reset_en_o !== 1'b1 || forced_o !== 1'b1) begin n_err++;
            $display("FAIL timeout_assert: got soft %b forced %b want 1 1", soft_reset_en_o,
                     forced_o); end
        for (int i = 0; i < Pulse + 4 && soft_reset_en_o; i++) tick();
        n_vec++; if (soft_reset_en_o !== 1'b0) begin n_err++;
            $display("FAIL timeout_pulse_end: got %b want 0 within bound", soft_reset_en_o); end
        c_rstn_i = 1'b1;
        tick();
        n_vec++; if (busy_o !== 1'b0) begin n_err++;
            $display("FAIL timeout_done: got busy %b want 0", busy_o); end
        e = exp_q.pop_front();
        n_vec++;
        if (obs_q.size() == 0) begin n_err++;
            $display("FAIL timeout_sb: no pulse, want len %0d", e.len);
        end else begin
            o = obs_q.pop_front();
            if (o.len != e.len || o.cause !== e.cause || o.forced !== e.forced) begin n_err++;
                $display("FAIL timeout_sb: got %0d/%b/%b want %0d/%b/%b", o.len, o.cause,
                         o.forced, e.len, e.cause, e.forced); end
        end
    endtask

    task automatic test_release_hold();
        pulse_t e, o;
        cause_clr_i = 1'b1;
        tick(); cause_clr_i = 1'b0;
        n_vec++; if (cause_o !== CAUSE_POR || forced_o !== 1'b0) begin n_err++;
            $display("FAIL clear_idle: got %b/%b want 00/0", cause_o, forced_o); end
        c_rstn_i = 1'b0;
        sw_req_i = 1'b1; drain_ack_i = 1'b1;
        exp_q.push_back('{len: Pulse, cause: CAUSE_SW, forced: 1'b0});
        tick(); sw_req_i = 1'b0; cause_clr_i = 1'b1;
        tick(); cause_clr_i = 1'b0; drain_ack_i = 1'b0;
        n_vec++; if (soft_reset_en_o !== 1'b1) begin n_err++;
            $display("FAIL min_drain_dwell: got soft %b want 1", soft_reset_en_o); end
        n_vec++; if (cause_o !== CAUSE_SW) begin n_err++;
            $display("FAIL clear_vs_update: got %b want 01", cause_o); end
        repeat (Pulse) tick();
        n_vec++; if (soft_reset_en_o !== 1'b0 || busy_o !== 1'b1) begin n_err++;
            $display("FAIL hold_release: got soft %b busy %b want 0 1", soft_reset_en_o,
                     busy_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (busy_o !== 1'b1) begin n_err++;
                $display("FAIL hold_busy_%0d: got %b want 1", i, busy_o); end
        end
        c_rstn_i = 1'b1;
        tick();
        n_vec++; if (busy_o !== 1'b0 || drain_req_o !== 1'b0) begin n_err++;
            $display("FAIL hold_done: got busy %b drain %b want 0 0", busy_o, drain_req_o); end
        e = exp_q.pop_front();
        n_vec++;
        if (obs_q.size() == 0) begin n_err++;
            $display("FAIL hold_sb: no pulse, want len %0d", e.len);
        end else begin
            o = obs_q.pop_front();
            if (o.len != e.len || o.cause !== e.cause || o.forced !== e.forced) begin n_err++;
                $display("FAIL hold_sb: got %0d/%b/%b want %0d/%b/%b", o.len, o.cause,
                         o.forced, e.len, e.cause, e.forced); end
        end
    endtask

    task automatic test_back_to_back();
        pulse_t e, o;
        c_rstn_i = 1'b0;
        sw_req_i = 1'b1; drain_ack_i = 1'b1;
        exp_q.push_back('{len: Pulse, cause: CAUSE_SW, forced: 1'b0});
        tick();
        tick(); drain_ack_i = 1'b0;
        for (int i = 0; i < Pulse + 4 && soft_reset_en_o; i++) tick();
        n_vec++; if (soft_reset_en_o !== 1'b0) begin n_err++;
            $display("FAIL b2b_pulse_end: got %b want 0 within bound", soft_reset_en_o); end
        tick(); tick();
        sw_req_i = 1'b0; c_rstn_i = 1'b1;
        tick();
        n_vec++; if (busy_o !== 1'b0) begin n_err++;
            $display("FAIL b2b_done: got busy %b want 0", busy_o); end
        repeat (3) tick();
        n_vec++; if (busy_o !== 1'b0) begin n_err++;
            $display("FAIL b2b_not_queued: got busy %b want 0", busy_o); end
        n_vec++; if (obs_q.size() != 1) begin n_err++;
            $display("FAIL b2b_pulse_count: got %0d want 1", obs_q.size()); end
        e = exp_q.pop_front();
        n_vec++;
        if (obs_q.size() == 0) begin n_err++;
            $display("FAIL b2b_sb: no pulse, want len %0d", e.len);
        end else begin
            o = obs_q.pop_front();
            if (o.len != e.len || o.cause !== e.cause || o.forced !== e.forced) begin n_err++;
                $display("FAIL b2b_sb: got %0d/%b/%b want %0d/%b/%b", o.len, o.cause,
                         o.forced, e.len, e.cause, e.forced); end
        end
        obs_q.delete();
    endtask

`ifdef RST_REQ_CTRL_WDT_EN
    task automatic test_wdt();
        pulse_t e, o;
        // 0: plain fire, 1: kicked at cycle 3, 2: coincident software request.
        for (int k = 0; k < 3; k++) begin
            wdt_en_i = 1'b0;
            tick();
            c_rstn_i = 1'b0; wdt_val_i = WdtW'(5); wdt_en_i = 1'b1;
            exp_q.push_back('{len: Pulse, cause: CAUSE_WDT, forced: 1'b0});
            if (k == 1) begin
                repeat (3) tick();
                wdt_kick_i = 1'b1;
                tick(); wdt_kick_i = 1'b0;
                repeat (4) tick();
            end else begin
                repeat (5) tick();
            end
            if (k == 2) sw_req_i = 1'b1;
            n_vec++; if (drain_req_o !== 1'b0) begin n_err++;
                $display("FAIL wdt_early_%0d: got drain %b want 0", k, drain_req_o); end
            tick(); sw_req_i = 1'b0;
            n_vec++; if (drain_req_o !== 1'b1) begin n_err++;
                $display("FAIL wdt_fire_%0d: got drain %b want 1", k, drain_req_o); end
            drain_ack_i = 1'b1;
            tick(); drain_ack_i = 1'b0;
            n_vec++; if (cause_o !== CAUSE_WDT) begin n_err++;
                $display("FAIL wdt_cause_%0d: got %b want 10", k, cause_o); end
            for (int i = 0; i < Pulse + 4 && soft_reset_en_o; i++) tick();
            c_rstn_i = 1'b1;
            tick();
            n_vec++; if (busy_o !== 1'b0) begin n_err++;
                $display("FAIL wdt_done_%0d: got busy %b want 0", k, busy_o); end
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin n_err++;
                $display("FAIL wdt_sb_%0d: no pulse, want len %0d", k, e.len);
            end else begin
                o = obs_q.pop_front();
                if (o.len != e.len || o.cause !== e.cause || o.forced !== e.forced) begin
                    n_err++;
                    $display("FAIL wdt_sb_%0d: got %0d/%b/%b want %0d/%b/%b", k, o.len,
                             o.cause, o.forced, e.len, e.cause, e.forced);
                end
            end
        end
        wdt_en_i = 1'b0;
        tick();
        wdt_val_i = '0; wdt_en_i = 1'b1;
        repeat (8) tick();
        n_vec++; if (busy_o !== 1'b0) begin n_err++;
            $display("FAIL wdt_zero_load: got busy %b want 0", busy_o); end
        wdt_en_i = 1'b0;
        tick();
    endtask
`endif

    task automatic test_async_reset();
        pulse_t e, o;
        c_rstn_i = 1'b0;
        sw_req_i = 1'b1; drain_ack_i = 1'b1;
        tick(); sw_req_i = 1'b0;
        tick(); drain_ack_i = 1'b0;
        n_vec++; if (soft_reset_en_o !== 1'b1) begin n_err++;
            $display("FAIL arst_in_assert: got soft %b want 1", soft_reset_en_o); end
        tick(); tick();
        rst_ni = 1'b0;
        #1;
        n_vec++; if (soft_reset_en_o !== 1'b0 || drain_req_o !== 1'b0 || busy_o !== 1'b0)
        begin n_err++;
            $display("FAIL arst_outputs: got soft %b drain %b busy %b want 0 0 0",
                     soft_reset_en_o, drain_req_o, busy_o); end
        n_vec++; if (cause_o !== CAUSE_POR || forced_o !== 1'b0) begin n_err++;
            $display("FAIL arst_cause: got %b/%b want 00/0", cause_o, forced_o); end
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        sw_req_i = 1'b1; drain_ack_i = 1'b1;
        exp_q.push_back('{len: Pulse, cause: CAUSE_SW, forced: 1'b0});
        tick(); sw_req_i = 1'b0;
        tick(); drain_ack_i = 1'b0;
        n_vec++; if (soft_reset_en_o !== 1'b1) begin n_err++;
            $display("FAIL arst_rerun: got soft %b want 1", soft_reset_en_o); end
        for (int i = 0; i < Pulse + 4 && soft_reset_en_o; i++) tick();
        c_rstn_i = 1'b1;
        tick();
        n_vec++; if (busy_o !== 1'b0) begin n_err++;
            $display("FAIL arst_rerun_done: got busy %b want 0", busy_o); end
        e = exp_q.pop_front();
        n_vec++;
        if (obs_q.size() == 0) begin n_err++;
            $display("FAIL arst_sb: no pulse, want len %0d", e.len);
        end else begin
            o = obs_q.pop_front();
            if (o.len != e.len || o.cause !== e.cause || o.forced !== e.forced) begin n_err++;
                $display("FAIL arst_sb: got %0d/%b/%b want %0d/%b/%b", o.len, o.cause,
                         o.forced, e.len, e.cause, e.forced); end
        end
    endtask

    task automatic test_final();
        tick(); tick();
        n_vec++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++;
            $display("FAIL sb_leftover: got exp %0d obs %0d want 0 0", exp_q.size(),
                     obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_sw_ack();
        test_timeout();
        test_release_hold();
        test_back_to_back();
`ifdef RST_REQ_CTRL_WDT_EN
        test_wdt();
`endif
        test_async_reset();
        test_final();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
